wb_regfile_unit: RTL and testbench
==================================

// Module: wb_regfile_unit
// PURPOSE
//  Write-back stage consumer of the EX/MEM->WB pipeline register: selects ALU result or load data,
//  commits it to a 16x16 general-purpose register file, and serves the decode stage's two read ports.
//  Same-cycle write-to-read bypass, a registered last-write record for EX forwarding, and a commit counter.
// PARAMETERS
//  DATA_W   16  register/data width
//  ADDR_W   4   register address width (2**ADDR_W registers)
//  CNT_W    16  width of commit counter
// PORTS
//  clk_in           in   1       single clock, all state on rising edge
//  rst_in           in   1       asynchronous, active-low reset
//  alu_result_in    in   DATA_W  ALU result from EX/MEM->WB register
//  ld_data_in       in   DATA_W  load data from EX/MEM->WB register
//  wb_addr_in       in   ADDR_W  destination register
//  wr_back_sel_in   in   1       1 = write ld_data_in, 0 = write alu_result_in
//  reg_wr_in        in   1       write enable for this cycle
//  rs1_addr_in      in   ADDR_W  read port 1 address (decode)
//  rs2_addr_in      in   ADDR_W  read port 2 address (decode)
//  rs1_data_out     out  DATA_W  read port 1 data (combinational)
//  rs2_data_out     out  DATA_W  read port 2 data (combinational)
//  dbg_addr_in      in   ADDR_W  debug read address
//  dbg_data_out     out  DATA_W  debug read data (raw array, no bypass)
//  fwd_valid_out    out  1       registered: previous cycle committed a write
//  fwd_addr_out     out  ADDR_W  registered: address of that write
//  fwd_data_out     out  DATA_W  registered: data of that write
//  commit_cnt_out   out  CNT_W   number of committed writes since reset
// BEHAVIOUR
//  - Reset (rst_in low, async): all 16 registers <= 0; fwd_valid/addr/data <= 0; commit_cnt <= 0.
//    Reset asserted mid-write: write is lost, array reads 0 after release.
//  - wb_data = wr_back_sel_in ? ld_data_in : alu_result_in (combinational).
//  - Commit: commit_en = reg_wr_in (qualified per CONFIGURATION). On rising edge with commit_en,
//    regs[wb_addr_in] <= wb_data; visible in array from next cycle.
//  - Reads: rsN_data_out = (commit_en && rsN_addr_in==wb_addr_in) ? wb_data : regs[rsN_addr_in].
//    Bypass is same-cycle, zero latency; both ports may bypass simultaneously.
//  - dbg_data_out = regs[dbg_addr_in], never bypassed (shows pre-commit value during a write cycle).
//  - Forward record, 1-cycle latency: each edge fwd_valid_out <= commit_en; when commit_en,
//    fwd_addr_out <= wb_addr_in and fwd_data_out <= wb_data; otherwise addr/data hold.
//  - Commit counter: +1 per committed write, wraps 2**CNT_W-1 -> 0, no saturation.
//  - reg_wr_in low: no array, counter or fwd_addr/data change; wr_back_sel_in/addr ignored.
//  - Back-to-back writes to same address: last write wins; each counts once.
// CONFIGURATION
//  R0_ZERO_EN defined: register 0 is hardwired zero. commit_en = reg_wr_in && (wb_addr_in!=0);
//    reads of address 0 (rs1, rs2, dbg) return 0, never bypassed; r0 writes do not bump counter
//    or fwd_valid_out.
//  R0_ZERO_EN undefined: register 0 is ordinary; commit_en = reg_wr_in.
// TESTING
//  1. Reset: hold rst_in low, drive reg_wr_in=1 -> all reads 0, commit_cnt_out=0, fwd_valid_out=0.
//  2. Write r5: alu=0x1234, sel=0, wr=1 -> next cycle rs1@5=0x1234, fwd_valid=1/addr=5/data=0x1234, cnt=1.
//  3. Load select + bypass: ld=0xBEEF, sel=1, addr=3, rs1=rs2=3 same cycle -> both 0xBEEF immediately,
//     dbg@3 still old value until edge.
//  4. reg_wr_in=0 with addr=7, alu=0xFFFF -> r7 unchanged, cnt unchanged, fwd_valid_out=0 next cycle.
//  5. r0: write 0xAAAA to addr 0 -> with R0_ZERO_EN reads 0, cnt unchanged; without, reads 0xAAAA, cnt+1.
//  6. Counter wrap: preload via 65536 writes -> commit_cnt_out returns to 0x0000; async reset mid-stream
//     clears array and counter immediately.

Source files
------------

// File: rtl/wb_regfile_unit_if.sv
// Write-back stage bundle: EX/MEM->WB payload, decode read ports, debug port, forward record, counter.
interface wb_regfile_unit_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 16
);
    logic [DATA_W-1:0] alu_result_in;
    logic [DATA_W-1:0] ld_data_in;
    logic [ADDR_W-1:0] wb_addr_in;
    logic              wr_back_sel_in;
    logic              reg_wr_in;
    logic [ADDR_W-1:0] rs1_addr_in;
    logic [ADDR_W-1:0] rs2_addr_in;
    logic [DATA_W-1:0] rs1_data_out;
    logic [DATA_W-1:0] rs2_data_out;
    logic [ADDR_W-1:0] dbg_addr_in;
    logic [DATA_W-1:0] dbg_data_out;
    logic              fwd_valid_out;
    logic [ADDR_W-1:0] fwd_addr_out;
    logic [DATA_W-1:0] fwd_data_out;
    logic [CNT_W-1:0]  commit_cnt_out;

    modport master (
        output alu_result_in, ld_data_in, wb_addr_in, wr_back_sel_in, reg_wr_in,
        output rs1_addr_in, rs2_addr_in, dbg_addr_in,
        input  rs1_data_out, rs2_data_out, dbg_data_out,
        input  fwd_valid_out, fwd_addr_out, fwd_data_out, commit_cnt_out
    );

    modport slave (
        input  alu_result_in, ld_data_in, wb_addr_in, wr_back_sel_in, reg_wr_in,
        input  rs1_addr_in, rs2_addr_in, dbg_addr_in,
        output rs1_data_out, rs2_data_out, dbg_data_out,
        output fwd_valid_out, fwd_addr_out, fwd_data_out, commit_cnt_out
    );
endinterface

// File: rtl/wb_regfile_unit.sv
// Write-back stage: result select, register file commit with same-cycle read bypass,
// last-write forward record and commit counter. Optional macro R0_ZERO_EN hardwires r0 to zero.
module wb_regfile_unit #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input logic              clk_in,
    input logic              rst_in,
    wb_regfile_unit_if.slave bus
);
    localparam int unsigned NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] wb_data_c;
    logic              commit_en_c;
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  commit_cnt;

    // Commit qualification; reset also masks the bypass so reads show the cleared array.
    always_comb begin
        wb_data_c = bus.wr_back_sel_in ? bus.ld_data_in : bus.alu_result_in;
`ifdef R0_ZERO_EN
        commit_en_c = rst_in && bus.reg_wr_in && (bus.wb_addr_in != ADDR_W'(0));
`else
        commit_en_c = rst_in && bus.reg_wr_in;
`endif
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (commit_en_c) begin
            regs[bus.wb_addr_in] <= wb_data_c;
        end
    end

    // Forward record and commit counter; addr/data hold when no commit.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            fwd_valid  <= 1'b0;
            fwd_addr   <= '0;
            fwd_data   <= '0;
            commit_cnt <= '0;
        end else begin
            fwd_valid <= commit_en_c;
            if (commit_en_c) begin
                fwd_addr   <= bus.wb_addr_in;
                fwd_data   <= wb_data_c;
                commit_cnt <= commit_cnt + CNT_W'(1);
            end
        end
    end

    // Decode read ports bypass the in-flight write; debug port shows the raw array.
    always_comb begin
        bus.rs1_data_out = regs[bus.rs1_addr_in];
        bus.rs2_data_out = regs[bus.rs2_addr_in];
        bus.dbg_data_out = regs[bus.dbg_addr_in];
        if (commit_en_c && (bus.rs1_addr_in == bus.wb_addr_in)) begin
            bus.rs1_data_out = wb_data_c;
        end
        if (commit_en_c && (bus.rs2_addr_in == bus.wb_addr_in)) begin
            bus.rs2_data_out = wb_data_c;
        end
`ifdef R0_ZERO_EN
        if (bus.rs1_addr_in == ADDR_W'(0)) bus.rs1_data_out = '0;
        if (bus.rs2_addr_in == ADDR_W'(0)) bus.rs2_data_out = '0;
        if (bus.dbg_addr_in == ADDR_W'(0)) bus.dbg_data_out = '0;
`endif
    end

    always_comb begin
        bus.fwd_valid_out  = fwd_valid;
        bus.fwd_addr_out   = fwd_addr;
        bus.fwd_data_out   = fwd_data;
        bus.commit_cnt_out = commit_cnt;
    end
endmodule

// File: tb/tb_wb_regfile_unit.sv
// Scoreboard bench for wb_regfile_unit: driver pushes expected outputs from an array model,
// a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_wb_regfile_unit;
`ifdef R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    typedef struct {
        logic [15:0] rs1;
        logic [15:0] rs2;
        logic [15:0] dbg;
        logic        fv;
        logic [3:0]  fa;
        logic [15:0] fd;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    bit [15:0] m_regs [16];
    bit        m_fv;
    bit [3:0]  m_fa;
    bit [15:0] m_fd;
    bit [15:0] m_cnt;

    wb_regfile_unit_if #(.DATA_W(16), .ADDR_W(4), .CNT_W(16)) bus ();

    wb_regfile_unit #(.DATA_W(16), .ADDR_W(4), .CNT_W(16)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endfunction

    // Monitor: every cycle is a transaction, sampled mid-period.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("rs1_data", 32'(bus.rs1_data_out), 32'(e.rs1));
            check("rs2_data", 32'(bus.rs2_data_out), 32'(e.rs2));
            check("dbg_data", 32'(bus.dbg_data_out), 32'(e.dbg));
            check("fwd_valid", 32'(bus.fwd_valid_out), 32'(e.fv));
            check("fwd_addr", 32'(bus.fwd_addr_out), 32'(e.fa));
            check("fwd_data", 32'(bus.fwd_data_out), 32'(e.fd));
            check("commit_cnt", 32'(bus.commit_cnt_out), 32'(e.cnt));
        end
    end

    function automatic bit [15:0] model_read(bit [3:0] ra, bit ce, bit [3:0] wa, bit [15:0] wd,
                                             bit bypass);
        if (R0Z && ra == 4'd0) return 16'h0;
        if (bypass && ce && ra == wa) return wd;
        return m_regs[ra];
    endfunction

    // One cycle: drive after the edge, push expectation, then advance the model past the next edge.
    task automatic step(bit wr, bit sel, bit [3:0] wa, bit [15:0] alu, bit [15:0] ld,
                        bit [3:0] r1, bit [3:0] r2, bit [3:0] dbg);
        exp_t e;
        bit        ce;
        bit [15:0] wd;
        @(posedge clk);
        #1;
        bus.reg_wr_in      = wr;
        bus.wr_back_sel_in = sel;
        bus.wb_addr_in     = wa;
        bus.alu_result_in  = alu;
        bus.ld_data_in     = ld;
        bus.rs1_addr_in    = r1;
        bus.rs2_addr_in    = r2;
        bus.dbg_addr_in    = dbg;
        ce = wr && !(R0Z && wa == 4'd0);
        wd = sel ? ld : alu;
        e.rs1 = model_read(r1, ce, wa, wd, 1'b1);
        e.rs2 = model_read(r2, ce, wa, wd, 1'b1);
        e.dbg = model_read(dbg, ce, wa, wd, 1'b0);
        e.fv  = m_fv;
        e.fa  = m_fa;
        e.fd  = m_fd;
        e.cnt = m_cnt;
        sb_q.push_back(e);
        m_fv = ce;
        if (ce) begin
            m_regs[wa] = wd;
            m_fa  = wa;
            m_fd  = wd;
            m_cnt = m_cnt + 16'd1;
        end
    endtask

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = 16'h0;
        m_fv  = 1'b0;
        m_fa  = 4'h0;
        m_fd  = 16'h0;
        m_cnt = 16'h0;
    endtask

    // Async reset away from the clock edge while a write is presented; everything reads zero at once.
    task automatic async_reset();
        @(negedge clk);
        #1;
        bus.reg_wr_in      = 1'b1;
        bus.wr_back_sel_in = 1'b0;
        bus.alu_result_in  = 16'h5A5A;
        bus.ld_data_in     = 16'hC3C3;
        rst_n = 1'b0;
        #1;
        check("rst_cnt", 32'(bus.commit_cnt_out), 32'h0);
        check("rst_fwd_valid", 32'(bus.fwd_valid_out), 32'h0);
        check("rst_fwd_addr", 32'(bus.fwd_addr_out), 32'h0);
        check("rst_fwd_data", 32'(bus.fwd_data_out), 32'h0);
        for (int i = 0; i < 16; i++) begin
            bus.wb_addr_in  = 4'(i);
            bus.rs1_addr_in = 4'(i);
            bus.rs2_addr_in = 4'(i);
            bus.dbg_addr_in = 4'(i);
            #1;
            check("rst_rs1", 32'(bus.rs1_data_out), 32'h0);
            check("rst_rs2", 32'(bus.rs2_data_out), 32'h0);
            check("rst_dbg", 32'(bus.dbg_data_out), 32'h0);
        end
        model_reset();
        @(posedge clk);
        #2;
        bus.reg_wr_in = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [15:0] held;
        bus.reg_wr_in = 1'b0; bus.wr_back_sel_in = 1'b0; bus.wb_addr_in = 4'h0;
        bus.alu_result_in = 16'h0; bus.ld_data_in = 16'h0;
        bus.rs1_addr_in = 4'h0; bus.rs2_addr_in = 4'h0; bus.dbg_addr_in = 4'h0;
        model_reset();
        async_reset();
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 4'(i), 4'(i), 4'(i));

        // Directed: ALU write to r5, then read back and forward record.
        step(1'b1, 1'b0, 4'd5, 16'h1234, 16'h0000, 4'd1, 4'd2, 4'd5);
        step(1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 4'd5, 4'd5, 4'd5);
        // Load select with double bypass; debug still shows old r3.
        step(1'b1, 1'b0, 4'd3, 16'h1111, 16'h0000, 4'd0, 4'd0, 4'd0);
        step(1'b1, 1'b1, 4'd3, 16'h0000, 16'hBEEF, 4'd3, 4'd3, 4'd3);
        step(1'b0, 1'b0, 4'd3, 16'h0000, 16'h0000, 4'd3, 4'd3, 4'd3);
        // Write disabled: r7 untouched, counter and fwd addr/data hold.
        step(1'b0, 1'b0, 4'd7, 16'hFFFF, 16'hFFFF, 4'd7, 4'd7, 4'd7);
        step(1'b0, 1'b0, 4'd7, 16'h0000, 16'h0000, 4'd7, 4'd7, 4'd7);
        // r0 write.
        step(1'b1, 1'b0, 4'd0, 16'hAAAA, 16'h0000, 4'd0, 4'd0, 4'd0);
        step(1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd0);
        // Back-to-back same address: last wins.
        step(1'b1, 1'b0, 4'd9, 16'h0101, 16'h0000, 4'd9, 4'd9, 4'd9);
        step(1'b1, 1'b1, 4'd9, 16'h0000, 16'h0202, 4'd9, 4'd9, 4'd9);
        step(1'b0, 1'b0, 4'd9, 16'h0000, 16'h0000, 4'd9, 4'd9, 4'd9);

        // Randomized traffic with frequent address collisions.
        for (int n = 0; n < 3000; n++) begin
            bit [3:0] wa, r1, r2, dg;
            wa = 4'($urandom_range(0, 15));
            r1 = ($urandom_range(0, 1) == 1) ? wa : 4'($urandom_range(0, 15));
            r2 = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
            dg = ($urandom_range(0, 1) == 1) ? wa : 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), wa,
                 16'($urandom), 16'($urandom), r1, r2, dg);
        end

        // Counter wrap: 65536 commits return the counter to its starting value.
        held = m_cnt;
        for (int n = 0; n < 65536; n++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        step(1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 4'd1, 4'd2, 4'd3);
        @(negedge clk);
        #1;
        check("cnt_wrap", 32'(bus.commit_cnt_out), 32'(held));

        // Reset mid-stream, then confirm the array stayed clear.
        for (int n = 0; n < 8; n++) step(1'b1, 1'b0, 4'(n + 1), 16'($urandom), 16'h0, 4'(n), 4'(n), 4'(n));
        async_reset();
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 4'(i), 4'(15 - i), 4'(i));
        for (int n = 0; n < 200; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                 16'($urandom), 16'($urandom), 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
